lambert_shade: RTL and testbench
================================

Name: lambert_shade

Overview:
- Downstream consumer of vector_normalize. Takes a unit surface normal and a light direction, and produces one diffuse intensity per element.
- Formula: intensity = AMBIENT + (one - AMBIENT) * clamp(dot(normal, light), 0, one).
- 3-stage elastic pipeline with valid/ready handshakes on input and output, plus a tag carried alongside each element.
- Normalize has fixed latency and cannot stall, so the issuing controller must hold credit for it; this block never drops an accepted element.

Parameters:
- TAG_W, 16, width of the sideband tag (pixel/fragment index) passed through unchanged.
- AMBIENT, (1 << (`FIXED_FRACTION_W-3)), ambient floor as a raw fixed_point_t value; legal range 0..one.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  normal, light and in_tag are valid this cycle.
- in_ready  output  1  block accepts the element this cycle.
- normal  input  vector_t  normalized surface normal from vector_normalize.
- light  input  vector_t  light direction (normalization not required).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  intensity and out_tag are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- intensity  output  fixed_point_t  shaded value in [AMBIENT, one].
- out_tag  output  TAG_W  tag belonging to intensity.

Behaviour:
- Reset (async, rst_n low): all stage valid bits go to 0, so out_valid=0, intensity=0, out_tag=0. in_ready goes to 1 once rst_n is high.
- Reset mid-operation: every in-flight element is discarded. No output appears afterwards for elements accepted before the reset.
- Handshake:
  - Transfer occurs when valid && ready are both high.
  - out_valid, intensity and out_tag stay stable while out_valid && !out_ready.
  - in_ready may depend combinationally on out_ready; it must not depend on in_valid.
- Stage k load rule: stage k loads when (!v_k || adv_k+1); adv_3 = out_ready. in_ready = load condition of S1.
  - Bubbles collapse: an empty stage fills even while downstream is stalled.
- S1: register the combinational dot product of normal and light, its overflow flag, and the tag.
- S2: clamp the S1 result.
  - overflow -> c = one.
  - dot < 0 -> c = 0.
  - dot > one -> c = one.
  - otherwise c = dot.
- S3:
  - Compute the 2*FIXED_W-bit product p = (one - AMBIENT) * c.
  - intensity = AMBIENT + (p >> FIXED_FRACTION_W), truncating (both operands non-negative, so this is a floor).
  - The result is ≤ one by construction, so no saturation is needed.
- Latency: exactly 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 element per cycle.
- Capacity: 3 elements maximum. With out_ready low and all stages full, in_ready=0.
- Simultaneous accept and emit while full is allowed: in_ready=1 when out_ready=1. Ordering is strictly FIFO.
- Tags travel with their data through every stage and are never reordered.

Decomposition:
- fixed_point package gains:
  - FIXED_ONE constant.
  - function fixed_clamp_unit(value, overflow), implementing the S2 rule.
  - function fixed_mul_trunc (widening multiply with truncating shift back to fixed_point_t).
- vector package: no changes. The block reuses vector_t and instantiates the existing vector_dot_product for S1.
- One natural sub-module: pipe_stage_ctrl, holding a valid flop and the load/advance logic. It is instanced three times.

Test Plan:
All scenarios use FIXED_W=16, FIXED_FRACTION_W=8 (one=0x0100) and default AMBIENT=0x0020.
- normal=(0,0,0x0100), light=(0,0,0x0100), tag=5, out_ready=1 -> out_valid exactly 3 cycles later, intensity=0x0100, out_tag=5.
- light=(0,0,0xFF00) (-1.0) -> dot negative, c=0, intensity=0x0020. light=(0,0,0x0080) -> intensity=0x0020+0x0070=0x0090.
- normal=(0x7F00,0,0), light=(0x7F00,0,0) -> dot overflow flagged, intensity=0x0100.
- Backpressure:
  - Stream 6 elements, tags 1..6, with out_ready=0 for 5 cycles -> exactly 3 accepted, in_ready=0 afterwards, out_tag=1 held stable.
  - Release out_ready -> tags 1..6 emerge in order with no loss or duplication.
- Back-to-back 20 elements with out_ready=1 -> one output per cycle, continuous out_valid, in_ready never drops.
- Assert rst_n low for 1 cycle with 2 elements in flight -> out_valid=0 and intensity=0 immediately (async). Neither element ever appears. The next input emerges after 3 cycles.

Source files
------------

// File: rtl/lambert_shade_pkg.sv
// Package for lambert_shade: fixed-point and vector types plus the helpers
// used by the shading pipeline.
//   fixed_point_t    : signed FIXED_W-bit value with FIXED_FRACTION_W fraction bits
//   vector_t         : packed {x, y, z} of fixed_point_t
//   vector_dot       : combinational dot product with overflow flag
//   fixed_clamp_unit : clamp a dot result into [0, one]
//   fixed_mul_trunc  : widening multiply, truncated back to fixed_point_t
package lambert_shade_pkg;

    localparam int FIXED_W          = 16;
    localparam int FIXED_FRACTION_W = 8;
    // Width of the dot-product accumulator: three full products plus carry room.
    localparam int ACC_W            = 2 * FIXED_W + 2;

    typedef logic signed [FIXED_W-1:0] fixed_point_t;

    typedef struct packed {
        fixed_point_t x;
        fixed_point_t y;
        fixed_point_t z;
    } vector_t;

    typedef struct packed {
        fixed_point_t value;
        logic         overflow;
    } dot_result_t;

    localparam fixed_point_t FIXED_ZERO = 16'sd0;
    localparam fixed_point_t FIXED_ONE  = 16'sd1 <<< FIXED_FRACTION_W;

    // Exact sum of products, then one arithmetic shift back to the fixed format.
    // Overflow means the shifted sum does not fit in fixed_point_t.
    function automatic dot_result_t vector_dot(input vector_t a, input vector_t b);
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] sh;
        dot_result_t             r;
        acc = ACC_W'(a.x) * ACC_W'(b.x)
            + ACC_W'(a.y) * ACC_W'(b.y)
            + ACC_W'(a.z) * ACC_W'(b.z);
        sh         = acc >>> FIXED_FRACTION_W;
        r.value    = sh[FIXED_W-1:0];
        r.overflow = (sh[ACC_W-1:FIXED_W-1] != {(ACC_W - FIXED_W + 1){sh[FIXED_W-1]}});
        return r;
    endfunction

    // Overflowed results saturate high regardless of sign.
    function automatic fixed_point_t fixed_clamp_unit(input fixed_point_t value,
                                                      input logic         overflow);
        fixed_point_t c;
        if (overflow) begin
            c = FIXED_ONE;
        end else if (value < FIXED_ZERO) begin
            c = FIXED_ZERO;
        end else if (value > FIXED_ONE) begin
            c = FIXED_ONE;
        end else begin
            c = value;
        end
        return c;
    endfunction

    // Truncating shift; callers pass non-negative operands, so this is a floor.
    function automatic fixed_point_t fixed_mul_trunc(input fixed_point_t a,
                                                     input fixed_point_t b);
        logic signed [2*FIXED_W-1:0] p;
        p = (2*FIXED_W)'(a) * (2*FIXED_W)'(b);
        return fixed_point_t'(p >>> FIXED_FRACTION_W);
    endfunction

endpackage

// File: rtl/lambert_shade_pipe_stage_ctrl.sv
// Valid flop plus load/advance logic for one elastic pipeline stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   up_valid_i  : upstream stage (or input) holds a valid element
//   down_adv_i  : downstream will take this stage's element this cycle
//   load_o      : this stage may load (empty, or its element is leaving)
//   en_o        : data registers of this stage should capture
//   valid_o     : this stage holds a valid element
module pipe_stage_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid_i,
    input  logic down_adv_i,
    output logic load_o,
    output logic en_o,
    output logic valid_o
);

    logic valid_q;
    logic valid_d;

    // An empty stage loads even while downstream stalls, so bubbles collapse.
    always_comb begin
        load_o = !valid_q || down_adv_i;
        en_o   = load_o && up_valid_i;
        if (load_o) begin
            valid_d = up_valid_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage valid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/lambert_shade.sv
// Lambert diffuse shader: intensity = AMBIENT + (one - AMBIENT) * clamp(dot(n, l), 0, one)
// as a 3-stage elastic valid/ready pipeline with a tag carried per element.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake for normal, light, in_tag
//   out_valid / out_ready: output handshake for intensity, out_tag
//   intensity            : shaded value in [AMBIENT, one]
module lambert_shade
    import lambert_shade_pkg::*;
#(
    parameter int           TAG_W   = 16,
    parameter fixed_point_t AMBIENT = 16'sd1 <<< (FIXED_FRACTION_W - 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  vector_t          normal,
    input  vector_t          light,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output fixed_point_t     intensity,
    output logic [TAG_W-1:0] out_tag
);

    logic ld1_s, ld2_s, ld3_s;
    logic en1_s, en2_s, en3_s;
    logic v1_s, v2_s, v3_s;

    dot_result_t  dot_s;
    fixed_point_t s1_dot_q, s1_dot_d;
    logic         s1_ovf_q, s1_ovf_d;
    fixed_point_t s2_c_q, s2_c_d;
    fixed_point_t s3_int_q, s3_int_d;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;

    // Each stage advances when the next one loads; the last follows out_ready.
    pipe_stage_ctrl u_stage1 (.clk(clk), .rst_n(rst_n), .up_valid_i(in_valid), .down_adv_i(ld2_s),
                              .load_o(ld1_s), .en_o(en1_s), .valid_o(v1_s));
    pipe_stage_ctrl u_stage2 (.clk(clk), .rst_n(rst_n), .up_valid_i(v1_s), .down_adv_i(ld3_s),
                              .load_o(ld2_s), .en_o(en2_s), .valid_o(v2_s));
    pipe_stage_ctrl u_stage3 (.clk(clk), .rst_n(rst_n), .up_valid_i(v2_s), .down_adv_i(out_ready),
                              .load_o(ld3_s), .en_o(en3_s), .valid_o(v3_s));

    assign dot_s = vector_dot(normal, light);

    // Per-stage datapath: dot product, clamp, ambient blend.
    always_comb begin
        s1_dot_d = dot_s.value;
        s1_ovf_d = dot_s.overflow;
        s2_c_d   = fixed_clamp_unit(s1_dot_q, s1_ovf_q);
        s3_int_d = AMBIENT + fixed_mul_trunc(FIXED_ONE - AMBIENT, s2_c_q);
    end

    // S1 registers: dot product, overflow flag and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dot_q <= FIXED_ZERO;
            s1_ovf_q <= 1'b0;
            s1_tag_q <= {TAG_W{1'b0}};
        end else if (en1_s) begin
            s1_dot_q <= s1_dot_d;
            s1_ovf_q <= s1_ovf_d;
            s1_tag_q <= in_tag;
        end
    end

    // S2 registers: clamped dot and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_c_q   <= FIXED_ZERO;
            s2_tag_q <= {TAG_W{1'b0}};
        end else if (en2_s) begin
            s2_c_q   <= s2_c_d;
            s2_tag_q <= s1_tag_q;
        end
    end

    // S3 registers: final intensity and tag; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_int_q <= FIXED_ZERO;
            s3_tag_q <= {TAG_W{1'b0}};
        end else if (en3_s) begin
            s3_int_q <= s3_int_d;
            s3_tag_q <= s2_tag_q;
        end
    end

    assign in_ready  = ld1_s;
    assign out_valid = v3_s;
    assign intensity = s3_int_q;
    assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_lambert_shade.sv
// Self-checking bench for lambert_shade (FIXED_W=16, FRACTION=8, AMBIENT=0x0020).
module tb_lambert_shade;
    import lambert_shade_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    vector_t      normal;
    vector_t      light;
    logic [15:0]  in_tag;
    logic         out_valid;
    logic         out_ready;
    fixed_point_t intensity;
    logic [15:0]  out_tag;

    always #5 clk = ~clk;

    lambert_shade #(.TAG_W(16), .AMBIENT(16'sh0020)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .normal(normal), .light(light), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .intensity(intensity), .out_tag(out_tag)
    );

    typedef struct { logic [15:0] inten; logic [15:0] tag; } exp_t;
    typedef struct { vector_t n; vector_t l; logic [15:0] tag; logic [15:0] exp_int; } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    int   cyc = 0;
    int   emitted = 0;
    int   first_c = -1;
    int   last_c = -1;
    logic last_acc = 1'b0;
    logic stall_q = 1'b0;
    logic [15:0] h_int, h_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vector_t mkv(input fixed_point_t x, input fixed_point_t y, input fixed_point_t z);
        vector_t v;
        v.x = x; v.y = y; v.z = z;
        return v;
    endfunction

    // Reference: exact real-valued dot in 1/65536 units, floored to 1/256,
    // clamped, then blended with the ambient floor.
    function automatic logic [15:0] model(input vector_t n, input vector_t l);
        longint s, d, c;
        s = longint'(n.x) * longint'(l.x) + longint'(n.y) * longint'(l.y)
          + longint'(n.z) * longint'(l.z);
        d = s >>> 8;
        if (d > 64'sd32767 || d < -64'sd32768) c = 256;
        else if (d < 0) c = 0;
        else if (d > 256) c = 256;
        else c = d;
        return 16'(32 + ((224 * c) / 256));
    endfunction

    function automatic fixed_point_t rand_comp();
        if ($urandom_range(0, 9) == 0) return fixed_point_t'($urandom());
        return fixed_point_t'($urandom_range(0, 640)) - 16'sd320;
    endfunction

    // One clock of scoreboard activity: sample just after the negedge,
    // record the handshakes due at the next posedge, then move on.
    task automatic cycle();
        exp_t e;
        #1;
        cyc++;
        if (stall_q) begin
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold intensity", {16'd0, intensity}, {16'd0, h_int});
            check("hold out_tag", {16'd0, out_tag}, {16'd0, h_tag});
        end
        if (out_valid && out_ready) begin
            emitted++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious output: tag 0x%0h with nothing outstanding", out_tag);
            end else begin
                e = q.pop_front();
                check("sb intensity", {16'd0, intensity}, {16'd0, e.inten});
                check("sb out_tag", {16'd0, out_tag}, {16'd0, e.tag});
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) q.push_back('{model(normal, light), in_tag});
        stall_q = out_valid && !out_ready;
        h_int   = intensity;
        h_tag   = out_tag;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0 && !out_valid) break;
            cycle();
        end
        check("drain queue empty", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        int          lat, acc_cnt, drops, spur, guard;
        logic [15:0] tag_n;

        tbl[0] = '{mkv(16'sh0000, 16'sh0000, 16'sh0100), mkv(16'sh0000, 16'sh0000, 16'sh0100), 16'd5,  16'h0100};
        tbl[1] = '{mkv(16'sh0000, 16'sh0000, 16'sh0100), mkv(16'sh0000, 16'sh0000, 16'shFF00), 16'd6,  16'h0020};
        tbl[2] = '{mkv(16'sh0000, 16'sh0000, 16'sh0100), mkv(16'sh0000, 16'sh0000, 16'sh0080), 16'd7,  16'h0090};
        tbl[3] = '{mkv(16'sh7F00, 16'sh0000, 16'sh0000), mkv(16'sh7F00, 16'sh0000, 16'sh0000), 16'd8,  16'h0100};
        tbl[4] = '{mkv(16'sh00B5, 16'sh00B5, 16'sh0000), mkv(16'sh0100, 16'sh0100, 16'sh0000), 16'd9,  16'h0100};
        tbl[5] = '{mkv(16'sh0080, 16'sh0000, 16'sh0080), mkv(16'sh0040, 16'sh0000, 16'sh0040), 16'd10, 16'h0058};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        normal = mkv(16'sh0, 16'sh0, 16'sh0); light = normal; in_tag = 16'd0;
        repeat (2) @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset intensity", {16'd0, intensity}, 32'd0);
        check("reset out_tag", {16'd0, out_tag}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Directed vectors: value, tag and 3-cycle latency.
        for (int i = 0; i < 6; i++) begin
            normal = tbl[i].n; light = tbl[i].l; in_tag = tbl[i].tag;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("latency[%0d]", i), lat, 32'd3);
            check($sformatf("intensity[%0d]", i), {16'd0, intensity}, {16'd0, tbl[i].exp_int});
            check($sformatf("out_tag[%0d]", i), {16'd0, out_tag}, {16'd0, tbl[i].tag});
            @(negedge clk);
        end

        // Backpressure: six offers against a stalled consumer.
        emitted = 0; out_ready = 1'b0; tag_n = 16'd1; acc_cnt = 0;
        normal = mkv(16'sh0, 16'sh0, 16'sh0100);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_tag = tag_n;
            light = mkv(16'sh0, 16'sh0, fixed_point_t'(tag_n * 16'd32));
            cycle();
            if (last_acc) begin acc_cnt++; tag_n++; end
        end
        check("bp accepted", acc_cnt, 32'd3);
        check("bp in_ready full", {31'd0, in_ready}, 32'd0);
        check("bp out_tag head", {16'd0, out_tag}, 32'd1);
        out_ready = 1'b1; guard = 0;
        while (tag_n <= 16'd6 && guard < 40) begin
            in_valid = 1'b1; in_tag = tag_n;
            light = mkv(16'sh0, 16'sh0, fixed_point_t'(tag_n * 16'd32));
            cycle();
            if (last_acc) tag_n++;
            guard++;
        end
        drain();
        check("bp emitted", emitted, 32'd6);

        // Back-to-back stream at full rate.
        emitted = 0; first_c = -1; drops = 0; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_tag = 16'(100 + k);
            normal = mkv(rand_comp(), rand_comp(), rand_comp());
            light  = mkv(rand_comp(), rand_comp(), rand_comp());
            cycle();
            if (!last_acc) drops++;
        end
        drain();
        check("b2b in_ready drops", drops, 32'd0);
        check("b2b emitted", emitted, 32'd20);
        check("b2b continuous", last_c - first_c, 32'd19);

        // Randomised valid/ready traffic against the reference model.
        emitted = 0; acc_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_tag = 16'($urandom());
            normal = mkv(rand_comp(), rand_comp(), rand_comp());
            light  = mkv(rand_comp(), rand_comp(), rand_comp());
            cycle();
            if (last_acc) acc_cnt++;
        end
        drain();
        check("random emitted == accepted", emitted, acc_cnt);

        // Reset with two elements in flight.
        out_ready = 1'b0; normal = mkv(16'sh0, 16'sh0, 16'sh0100); light = normal;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_tag = 16'(16'h0A0 + k);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check("async reset intensity", {16'd0, intensity}, 32'd0);
        check("async reset out_tag", {16'd0, out_tag}, 32'd0);
        q.delete(); stall_q = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_tag = 16'h0077;
        light = mkv(16'sh0, 16'sh0, 16'sh0080);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("post-reset latency", lat, 32'd3);
        check("post-reset out_tag", {16'd0, out_tag}, 32'h0077);
        check("post-reset intensity", {16'd0, intensity}, 32'h0090);
        spur = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        check("no stale outputs", spur, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
